rs_issue_scheduler: RTL and testbench
=====================================

// Module: rs_issue_scheduler
// PURPOSE
// Issue scheduler for the 16-row reservation station behind the dual-issue dispatch stage.
// Accepts up to 2 renamed instructions/cycle and tracks source readiness via FU wakeup broadcasts.
// Each cycle it selects, per functional unit, the oldest fully-ready row (ROB order) and issues it.
// Owns RS row allocation/free and the per-FU arbitration; the rows hold no operand data.
// PARAMETERS
// RS_DEPTH  16  reservation-station rows
// NUM_FU    3   functional units; fu_index 0..NUM_FU-1
// PREG_W    6   physical register tag width (64 pregs)
// ROB_W     4   ROB index width (16 entries)
// OP_W      7   opcode width
// PORTS
// clk            in   1           clock, all state on posedge
// rst_n          in   1           synchronous active-low reset
// flush          in   1           sync clear of all rows and issue regs
// rob_head       in   ROB_W       index of oldest in-flight ROB entry (age origin)
// disp_valid_1/2 in   1           dispatch slot request
// disp_op_1/2    in   OP_W        opcode
// disp_pd_1/2    in   PREG_W      dest preg
// disp_ps1_1/2   in   PREG_W      src1 preg;  disp_ps1_rdy_1/2 in 1: src1 ready at dispatch
// disp_ps2_1/2   in   PREG_W      src2 preg;  disp_ps2_rdy_1/2 in 1: src2 ready at dispatch
// disp_fu_1/2    in   2           target FU index
// disp_rob_1/2   in   ROB_W       ROB index
// disp_ready     out  1           free_count >= 2; both slots may be accepted this cycle
// wakeup_valid   in   NUM_FU      completion broadcast per FU
// wakeup_preg    in   NUM_FU*PREG_W  completed preg per FU (FU f at bits [f*PREG_W +: PREG_W])
// fu_ready       in   NUM_FU      FU f can take an instruction this cycle
// issue_valid    out  NUM_FU      registered issue strobe per FU
// issue_op/pd/ps1/ps2/rob  out  NUM_FU*width  registered issued fields, flattened as above
// free_count     out  5           number of free rows (0..16)
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): all rows invalid; issue_valid=0; issue_* fields=0; free_count=16.
// - Priority per edge: reset > flush > normal. Flush: rows invalid, issue_valid=0, free_count=16,
//   same-cycle dispatches and wakeups dropped.
// - Dispatch accepted only when disp_valid_x && disp_ready. disp_ready is combinational from
//   free_count (excludes rows freed by issue in the same cycle). Slot 1 takes lowest free row,
//   slot 2 the next lowest; slot 2 alone takes lowest free row. Written rows valid after the edge.
// - Wakeup: any row (or same-cycle dispatch) whose ps1/ps2 equals a valid wakeup_preg sets that
//   rdy bit at the edge (dispatch bypass: rdy = disp_rdy | match). Rdy bits never clear.
// - Select, per FU f, combinational: candidates = valid rows, fu_index==f, both rdy.
//   Age = (rob_index - rob_head) mod 2^ROB_W; smallest age wins; tie -> lower row index.
// - If fu_ready[f] and a candidate exists: at the edge the row is invalidated and its fields are
//   registered to issue_*[f] with issue_valid[f]=1 for exactly one cycle; else issue_valid[f]=0.
// - Rows are FU-partitioned, so at most one issue per FU and never the same row twice.
// - Latency: dispatch with both rdy at cycle t -> issue_valid at t+2 (given fu_ready).
//   Wakeup at cycle t for last pending source -> issue_valid at t+2.
// - free_count(next) = free_count - accepted_dispatches + issued_rows; never <0 or >16.
// - Full: free_count<2 -> disp_ready=0; dispatcher holds its inputs. free_count=1 still stalls.
// - fu_index >= NUM_FU at dispatch is illegal; simulation assertion fires, row never issues.
// - rob_head wrap (15->0) handled by modular age; ages of live rows are unique by construction.
// TESTING
// - Reset then idle -> free_count=16, disp_ready=1, issue_valid=0 every cycle.
// - Dispatch op add, fu=0, both rdy, rob=3, rob_head=3, fu_ready=1 at t -> issue_valid[0]=1 at t+2,
//   issue_rob=3, free_count back to 16 at t+3.
// - Row with ps1=40 not rdy; wakeup_valid[1]=1, wakeup_preg=40 at t -> issues at t+2; same-cycle
//   dispatch+wakeup of preg 40 -> issues 2 cycles after dispatch.
// - rob_head=14, ready rows fu=0 with rob 1 and 15 -> rob 15 issues first, rob 1 next cycle.
// - Fill 16 rows with fu_ready=0 -> disp_ready=0 at free_count=1 and 0; raise fu_ready[0..2]
//   -> three issues/cycle, free_count rises by 3/cycle, disp_ready returns at free_count>=2.
// - flush (and separately rst_n=0) with 8 valid rows and pending issue -> next cycle
//   issue_valid=0, free_count=16; no stale row issues afterwards.

Source files
------------

// File: rtl/rs_issue_scheduler.sv
// RS issue scheduler: 16-row reservation station with dual dispatch,
// source wakeup tracking and oldest-ready (ROB age) select per FU.
// Ports: clk/rst_n (sync, active low), flush, rob_head (age origin);
// disp_*_1/2 dispatch slots, disp_ready (>=2 free rows);
// wakeup_valid/preg per FU; fu_ready per FU;
// issue_valid/op/pd/ps1/ps2/rob registered per FU; free_count.
module rs_issue_scheduler #(
  parameter int RS_DEPTH = 16,
  parameter int NUM_FU   = 3,
  parameter int PREG_W   = 6,
  parameter int ROB_W    = 4,
  parameter int OP_W     = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [ROB_W-1:0]         rob_head,
  input  logic                     disp_valid_1,
  input  logic [OP_W-1:0]          disp_op_1,
  input  logic [PREG_W-1:0]        disp_pd_1,
  input  logic [PREG_W-1:0]        disp_ps1_1,
  input  logic                     disp_ps1_rdy_1,
  input  logic [PREG_W-1:0]        disp_ps2_1,
  input  logic                     disp_ps2_rdy_1,
  input  logic [1:0]               disp_fu_1,
  input  logic [ROB_W-1:0]         disp_rob_1,
  input  logic                     disp_valid_2,
  input  logic [OP_W-1:0]          disp_op_2,
  input  logic [PREG_W-1:0]        disp_pd_2,
  input  logic [PREG_W-1:0]        disp_ps1_2,
  input  logic                     disp_ps1_rdy_2,
  input  logic [PREG_W-1:0]        disp_ps2_2,
  input  logic                     disp_ps2_rdy_2,
  input  logic [1:0]               disp_fu_2,
  input  logic [ROB_W-1:0]         disp_rob_2,
  output logic                     disp_ready,
  input  logic [NUM_FU-1:0]        wakeup_valid,
  input  logic [NUM_FU*PREG_W-1:0] wakeup_preg,
  input  logic [NUM_FU-1:0]        fu_ready,
  output logic [NUM_FU-1:0]        issue_valid,
  output logic [NUM_FU*OP_W-1:0]   issue_op,
  output logic [NUM_FU*PREG_W-1:0] issue_pd,
  output logic [NUM_FU*PREG_W-1:0] issue_ps1,
  output logic [NUM_FU*PREG_W-1:0] issue_ps2,
  output logic [NUM_FU*ROB_W-1:0]  issue_rob,
  output logic [4:0]               free_count
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int ISS_W = $clog2(NUM_FU + 1);
  localparam logic [4:0] FULL = 5'(RS_DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] ps1;
    logic              rdy1;
    logic [PREG_W-1:0] ps2;
    logic              rdy2;
    logic [1:0]        fu;
    logic [ROB_W-1:0]  rob;
  } row_t;

  row_t                rows [RS_DEPTH];
  logic [RS_DEPTH-1:0] valid;

  function automatic logic woke(
    input logic [PREG_W-1:0]        p,
    input logic [NUM_FU-1:0]        wv,
    input logic [NUM_FU*PREG_W-1:0] wp
  );
    logic hit;
    hit = 1'b0;
    for (int f = 0; f < NUM_FU; f++)
      if (wv[f] && wp[f*PREG_W +: PREG_W] == p)
        hit = 1'b1;
    return hit;
  endfunction

  logic             acc1, acc2;
  logic             lo_ok, nx_ok;
  logic [IDX_W-1:0] lo, nx, idx1, idx2;
  row_t             d1, d2;

  assign disp_ready = free_count >= 5'd2;
  assign acc1 = disp_valid_1 && disp_ready;
  assign acc2 = disp_valid_2 && disp_ready;

  always_comb begin
    lo = '0;
    nx = '0;
    lo_ok = 1'b0;
    nx_ok = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!valid[i] && lo_ok && !nx_ok) begin
        nx = IDX_W'(i);
        nx_ok = 1'b1;
      end
      if (!valid[i] && !lo_ok) begin
        lo = IDX_W'(i);
        lo_ok = 1'b1;
      end
    end
  end

  // slot 2 falls back to the lowest row when slot 1 is idle
  assign idx1 = lo;
  assign idx2 = acc1 ? nx : lo;

  always_comb begin
    d1.op   = disp_op_1;
    d1.pd   = disp_pd_1;
    d1.ps1  = disp_ps1_1;
    d1.rdy1 = disp_ps1_rdy_1 |
              woke(disp_ps1_1, wakeup_valid, wakeup_preg);
    d1.ps2  = disp_ps2_1;
    d1.rdy2 = disp_ps2_rdy_1 |
              woke(disp_ps2_1, wakeup_valid, wakeup_preg);
    d1.fu   = disp_fu_1;
    d1.rob  = disp_rob_1;
    d2.op   = disp_op_2;
    d2.pd   = disp_pd_2;
    d2.ps1  = disp_ps1_2;
    d2.rdy1 = disp_ps1_rdy_2 |
              woke(disp_ps1_2, wakeup_valid, wakeup_preg);
    d2.ps2  = disp_ps2_2;
    d2.rdy2 = disp_ps2_rdy_2 |
              woke(disp_ps2_2, wakeup_valid, wakeup_preg);
    d2.fu   = disp_fu_2;
    d2.rob  = disp_rob_2;
  end

  logic [NUM_FU-1:0] cand, iss;
  logic [IDX_W-1:0]  sel [NUM_FU];
  logic [ROB_W-1:0]  best, age;

  // ascending scan with strict < keeps the lower row on equal age
  always_comb begin
    cand = '0;
    best = '0;
    age  = '0;
    for (int f = 0; f < NUM_FU; f++)
      sel[f] = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      best = '1;
      for (int i = 0; i < RS_DEPTH; i++) begin
        age = rows[i].rob - rob_head;
        if (valid[i] && rows[i].rdy1 && rows[i].rdy2 &&
            rows[i].fu == 2'(f) &&
            (!cand[f] || age < best)) begin
          cand[f] = 1'b1;
          best    = age;
          sel[f]  = IDX_W'(i);
        end
      end
    end
  end

  assign iss = cand & fu_ready;

  logic [RS_DEPTH-1:0] take;
  logic [ISS_W-1:0]    n_iss;

  always_comb begin
    take  = '0;
    n_iss = '0;
    for (int f = 0; f < NUM_FU; f++)
      if (iss[f]) begin
        take[sel[f]] = 1'b1;
        n_iss = n_iss + ISS_W'(1);
      end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid       <= '0;
      free_count  <= FULL;
      issue_valid <= '0;
      issue_op    <= '0;
      issue_pd    <= '0;
      issue_ps1   <= '0;
      issue_ps2   <= '0;
      issue_rob   <= '0;
      for (int i = 0; i < RS_DEPTH; i++)
        rows[i] <= '0;
    end else if (flush) begin
      valid       <= '0;
      free_count  <= FULL;
      issue_valid <= '0;
    end else begin
      free_count  <= free_count - (5'(acc1) + 5'(acc2))
                   + 5'(n_iss);
      issue_valid <= iss;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (take[i])
          valid[i] <= 1'b0;
        if (woke(rows[i].ps1, wakeup_valid, wakeup_preg))
          rows[i].rdy1 <= 1'b1;
        if (woke(rows[i].ps2, wakeup_valid, wakeup_preg))
          rows[i].rdy2 <= 1'b1;
      end
      if (acc1) begin
        assert (int'(disp_fu_1) < NUM_FU);
        rows[idx1]  <= d1;
        valid[idx1] <= 1'b1;
      end
      if (acc2) begin
        assert (int'(disp_fu_2) < NUM_FU);
        rows[idx2]  <= d2;
        valid[idx2] <= 1'b1;
      end
      for (int f = 0; f < NUM_FU; f++)
        if (iss[f]) begin
          issue_op[f*OP_W +: OP_W]     <= rows[sel[f]].op;
          issue_pd[f*PREG_W +: PREG_W] <= rows[sel[f]].pd;
          issue_ps1[f*PREG_W +: PREG_W] <= rows[sel[f]].ps1;
          issue_ps2[f*PREG_W +: PREG_W] <= rows[sel[f]].ps2;
          issue_rob[f*ROB_W +: ROB_W]  <= rows[sel[f]].rob;
        end
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler with a per-FU
// scoreboard of expected issues.
module tb_rs_issue_scheduler;

  localparam int NF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush;
  logic [3:0]  rob_head;
  logic        dv1, dv2;
  logic [6:0]  op1, op2;
  logic [5:0]  pd1, pd2, sa1, sa2, sb1, sb2;
  logic        ra1, ra2, rb1, rb2;
  logic [1:0]  fu1, fu2;
  logic [3:0]  rob1, rob2;
  logic        disp_ready;
  logic [2:0]  wv, fu_ready, issue_valid;
  logic [17:0] wp;
  logic [20:0] issue_op;
  logic [17:0] issue_pd, issue_ps1, issue_ps2;
  logic [11:0] issue_rob;
  logic [4:0]  free_count;

  rs_issue_scheduler dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .rob_head(rob_head),
    .disp_valid_1(dv1), .disp_op_1(op1), .disp_pd_1(pd1),
    .disp_ps1_1(sa1), .disp_ps1_rdy_1(ra1),
    .disp_ps2_1(sb1), .disp_ps2_rdy_1(rb1),
    .disp_fu_1(fu1), .disp_rob_1(rob1),
    .disp_valid_2(dv2), .disp_op_2(op2), .disp_pd_2(pd2),
    .disp_ps1_2(sa2), .disp_ps1_rdy_2(ra2),
    .disp_ps2_2(sb2), .disp_ps2_rdy_2(rb2),
    .disp_fu_2(fu2), .disp_rob_2(rob2),
    .disp_ready(disp_ready),
    .wakeup_valid(wv), .wakeup_preg(wp),
    .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_pd(issue_pd), .issue_ps1(issue_ps1),
    .issue_ps2(issue_ps2), .issue_rob(issue_rob),
    .free_count(free_count)
  );

  typedef logic [28:0] key_t;
  key_t q0[$], q1[$], q2[$];
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  function automatic key_t mk(input logic [3:0] rob,
                              input logic [5:0] a,
                              input logic [5:0] b);
    return {7'(rob) + 7'h10, 6'(rob) + 6'd20, a, b, rob};
  endfunction

  task automatic push(input logic [1:0] fu, input key_t k);
    case (fu)
      2'd0:    q0.push_back(k);
      2'd1:    q1.push_back(k);
      default: q2.push_back(k);
    endcase
  endtask

  task automatic idle();
    dv1 = 1'b0; dv2 = 1'b0; wv = '0;
  endtask

  task automatic put(input int s, input logic [1:0] fu,
                     input logic [3:0] rob,
                     input logic [5:0] a, input logic ra,
                     input logic [5:0] b, input logic rb,
                     input bit ex);
    if (s == 1) begin
      dv1 = 1'b1; op1 = 7'(rob) + 7'h10;
      pd1 = 6'(rob) + 6'd20;
      sa1 = a; ra1 = ra; sb1 = b; rb1 = rb;
      fu1 = fu; rob1 = rob;
    end else begin
      dv2 = 1'b1; op2 = 7'(rob) + 7'h10;
      pd2 = 6'(rob) + 6'd20;
      sa2 = a; ra2 = ra; sb2 = b; rb2 = rb;
      fu2 = fu; rob2 = rob;
    end
    if (ex) push(fu, mk(rob, a, b));
  endtask

  task automatic step();
    key_t got, e;
    bit have;
    @(posedge clk);
    @(negedge clk);
    for (int f = 0; f < NF; f++)
      if (issue_valid[f]) begin
        got = {issue_op[f*7 +: 7], issue_pd[f*6 +: 6],
               issue_ps1[f*6 +: 6], issue_ps2[f*6 +: 6],
               issue_rob[f*4 +: 4]};
        e = '0;
        have = 1'b1;
        if (f == 0 && q0.size() > 0) e = q0.pop_front();
        else if (f == 1 && q1.size() > 0) e = q1.pop_front();
        else if (f == 2 && q2.size() > 0) e = q2.pop_front();
        else have = 1'b0;
        chk($sformatf("issue_fu%0d", f), 32'(got),
            have ? 32'(e) : 32'hDEAD_BEEF);
      end
  endtask

  task automatic fill_pairs(input int n, input bit ex);
    for (int k = 0; k < n; k++) begin
      put(1, 2'((2*k) % 3), 4'(2*k), 6'd9, 1'b1, 6'd10, 1'b1, ex);
      put(2, 2'((2*k+1) % 3), 4'(2*k+1), 6'd9, 1'b1, 6'd10, 1'b1, ex);
      step(); idle();
      chk("fill_free", 32'(free_count), 32'(16 - 2*(k+1)));
      chk("fill_rdy", 32'(disp_ready), 32'(k < 7));
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; rob_head = '0;
    fu_ready = '0; wp = '0; idle();
    op1 = '0; pd1 = '0; sa1 = '0; sb1 = '0; ra1 = 0; rb1 = 0;
    op2 = '0; pd2 = '0; sa2 = '0; sb2 = '0; ra2 = 0; rb2 = 0;
    fu1 = '0; fu2 = '0; rob1 = '0; rob2 = '0;
    step(); step();
    chk("rst_valid", 32'(issue_valid), 32'd0);
    chk("rst_free", 32'(free_count), 32'd16);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_free", 32'(free_count), 32'd16);
      chk("idle_rdy", 32'(disp_ready), 32'd1);
      chk("idle_valid", 32'(issue_valid), 32'd0);
    end

    // single ready dispatch, two-cycle latency
    rob_head = 4'd3; fu_ready = 3'b111;
    put(1, 2'd0, 4'd3, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1);
    step(); idle();
    chk("t1_free", 32'(free_count), 32'd15);
    chk("t1_valid", 32'(issue_valid), 32'd0);
    step();
    chk("t2_valid", 32'(issue_valid), 32'b001);
    chk("t2_rob", 32'(issue_rob[3:0]), 32'd3);
    step();
    chk("t3_free", 32'(free_count), 32'd16);
    chk("t3_valid", 32'(issue_valid), 32'd0);

    // wakeup of a waiting row
    put(1, 2'd1, 4'd4, 6'd40, 1'b0, 6'd5, 1'b1, 1'b1);
    step(); idle(); step();
    chk("wk_wait", 32'(issue_valid), 32'd0);
    wv = 3'b010; wp = {6'd0, 6'd40, 6'd0};
    step(); wv = '0;
    chk("wk_t1", 32'(issue_valid), 32'd0);
    step();
    chk("wk_t2", 32'(issue_valid), 32'b010);

    // wakeup bypass in the dispatch cycle
    put(1, 2'd2, 4'd5, 6'd7, 1'b1, 6'd40, 1'b0, 1'b1);
    wv = 3'b001; wp = {12'd0, 6'd40};
    step(); idle();
    chk("byp_t1", 32'(issue_valid), 32'd0);
    step();
    chk("byp_t2", 32'(issue_valid), 32'b100);
    chk("byp_rob", 32'(issue_rob[11:8]), 32'd5);

    // only ps2 woken; ps1 must still block
    put(1, 2'd0, 4'd6, 6'd50, 1'b0, 6'd51, 1'b0, 1'b1);
    wv = 3'b100; wp = {6'd51, 12'd0};
    step(); idle(); step(); step();
    chk("neg_hold", 32'(issue_valid), 32'd0);
    chk("neg_free", 32'(free_count), 32'd15);
    wv = 3'b001; wp = {12'd0, 6'd50};
    step(); wv = '0; step();
    chk("neg_issue", 32'(issue_valid), 32'b001);

    // age across rob_head wrap
    rob_head = 4'd14;
    put(1, 2'd0, 4'd1, 6'd3, 1'b1, 6'd4, 1'b1, 1'b0);
    put(2, 2'd0, 4'd15, 6'd3, 1'b1, 6'd4, 1'b1, 1'b0);
    push(2'd0, mk(4'd15, 6'd3, 6'd4));
    push(2'd0, mk(4'd1, 6'd3, 6'd4));
    step(); idle(); step();
    chk("age_first", 32'(issue_rob[3:0]), 32'd15);
    step();
    chk("age_second", 32'(issue_rob[3:0]), 32'd1);
    step();
    chk("age_free", 32'(free_count), 32'd16);

    // fill to zero, stall, then drain three per cycle
    rob_head = 4'd0; fu_ready = 3'b000;
    fill_pairs(8, 1'b1);
    put(1, 2'd0, 4'd0, 6'd9, 1'b1, 6'd10, 1'b1, 1'b0);
    put(2, 2'd1, 4'd1, 6'd9, 1'b1, 6'd10, 1'b1, 1'b0);
    step(); idle();
    chk("full_hold", 32'(free_count), 32'd0);
    chk("full_valid", 32'(issue_valid), 32'd0);
    fu_ready = 3'b111;
    step();
    chk("drain_valid", 32'(issue_valid), 32'b111);
    chk("drain_free", 32'(free_count), 32'd3);
    chk("drain_rdy", 32'(disp_ready), 32'd1);
    for (int k = 1; k < 5; k++) begin
      step();
      chk("drain_step", 32'(free_count), 32'(3 + 3*k));
    end
    step();
    chk("drain_last", 32'(issue_valid), 32'b001);
    chk("drain_full", 32'(free_count), 32'd16);
    step();
    chk("drain_done", 32'(issue_valid), 32'd0);

    // one free row still stalls; clear with flush
    fu_ready = 3'b000;
    fill_pairs(7, 1'b0);
    put(1, 2'd2, 4'd14, 6'd9, 1'b1, 6'd10, 1'b1, 1'b0);
    step(); idle();
    chk("one_free", 32'(free_count), 32'd1);
    chk("one_rdy", 32'(disp_ready), 32'd0);
    put(1, 2'd0, 4'd15, 6'd9, 1'b1, 6'd10, 1'b1, 1'b0);
    step(); idle();
    chk("one_hold", 32'(free_count), 32'd1);
    flush = 1'b1;
    step(); flush = 1'b0;
    chk("fl15_free", 32'(free_count), 32'd16);

    // flush with 8 rows and issue in flight
    fill_pairs(4, 1'b1);
    fu_ready = 3'b111;
    step();
    chk("pre_flush", 32'(issue_valid), 32'b111);
    flush = 1'b1;
    put(1, 2'd0, 4'd8, 6'd9, 1'b1, 6'd10, 1'b1, 1'b0);
    step(); flush = 1'b0; idle();
    chk("flush_valid", 32'(issue_valid), 32'd0);
    chk("flush_free", 32'(free_count), 32'd16);
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_flush", 32'(issue_valid), 32'd0);
    end
    chk("post_flush_free", 32'(free_count), 32'd16);

    // reset with 8 rows and issue in flight
    fu_ready = 3'b000;
    fill_pairs(4, 1'b1);
    fu_ready = 3'b111;
    step();
    chk("pre_rst", 32'(issue_valid), 32'b111);
    rst_n = 1'b0;
    step(); rst_n = 1'b1;
    chk("rst2_valid", 32'(issue_valid), 32'd0);
    chk("rst2_free", 32'(free_count), 32'd16);
    chk("rst2_rob", 32'(issue_rob), 32'd0);
    chk("rst2_op", 32'(issue_op), 32'd0);
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst", 32'(issue_valid), 32'd0);
    end

    chk("sb_empty", 32'(q0.size() + q1.size() + q2.size()),
        32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
